ldst_mem_responder: RTL and testbench

//  Memory-side responder for the load/store unit's request interface.
//  - Accepts one load or store per transaction.
//  - Holds the data memory internally as a byte-strobed word array.
//  - Inserts configurable wait states and holds the pipeline stalled while busy.
//  - For loads, returns aligned, sign- or zero-extended data as a register-file write.

---
 rtl/ldst_resp_pkg.sv | 20 ++
 rtl/ldst_load_align.sv | 27 ++
 rtl/ldst_mem_responder.sv | 195 +++++++++++++++++++
 tb/tb_ldst_mem_responder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ldst_resp_pkg.sv
// Shared types and constants for the load/store memory responder.
package ldst_resp_pkg;

  localparam int unsigned WORD_BYTES       = 4;
  localparam int unsigned DEPTH_WORDS_DFLT = 1024;
  localparam int unsigned ADDR_W           = $clog2(DEPTH_WORDS_DFLT);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  // Reserved encoding 2'b11 behaves as a word access.
  function automatic size_t decode_size(input logic [1:0] sel);
    case (sel)
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/ldst_load_align.sv
// Load data alignment: picks the byte/half lane from a memory word and sign/zero extends it.
module ldst_load_align
  import ldst_resp_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] word_i,
  input  logic [1:0]       offset_i,
  input  size_t            size_i,
  input  logic             sign_i,
  output logic [WIDTH-1:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = 8'(word_i >> {offset_i, 3'b000});
    half_v = 16'(word_i >> {offset_i[1], 4'b0000});
    case (size_i)
      SZ_B:    data_o = {{(WIDTH-8){sign_i & byte_v[7]}}, byte_v};
      SZ_H:    data_o = {{(WIDTH-16){sign_i & half_v[15]}}, half_v};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/ldst_mem_responder.sv
// Memory-side responder for LSU requests: byte-strobed word memory, wait states, load writeback.
// Optional LDST_MISALIGN_CHK_EN rejects misaligned half/word accesses instead of aligning down.
module ldst_mem_responder
  import ldst_resp_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DFLT,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic             risc_clk,
  input  logic             risc_rst,
  input  logic             load_valid_in,
  input  logic             store_valid_in,
  input  logic [WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0] store_data_i,
  input  logic [1:0]       byte_sel_i,
  input  logic             sign_bit_i,
  input  logic [4:0]       rd_addr_i,
  output logic             stall_pipeline_o,
  output logic             reg_wr_en_o,
  output logic [4:0]       reg_wr_addr_o,
  output logic [WIDTH-1:0] reg_wr_data_o,
  output logic             store_done_o,
  output logic             misalign_err_o
);

  localparam int unsigned AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_CNT = 4'(WAIT_CYCLES);
  localparam bit          HAS_WAIT = (WAIT_CYCLES != 0);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             is_store_q, sign_q;
  size_t            size_q;
  logic [WIDTH-1:0] addr_q, data_q;
  logic [4:0]       rd_q;

  logic             any_valid, accept, do_resp, misalign, load_resp, mem_we;
  logic             cur_store, cur_sign;
  size_t            cur_size;
  logic [WIDTH-1:0] cur_addr, cur_data, wdata, rd_word, ld_data;
  logic [4:0]       cur_rd;
  logic [1:0]       off;
  logic [3:0]       strb;
  logic [AW-1:0]    idx;
  logic             unused_addr_hi;

  logic [WIDTH-1:0] mem [DEPTH_WORDS];

  assign any_valid = load_valid_in | store_valid_in;
  assign accept    = (state_q == IDLE) && any_valid;

  // Live inputs drive the response when it issues straight from IDLE; captured fields otherwise.
  always_comb begin
    if (state_q == IDLE) begin
      cur_store = store_valid_in;
      cur_sign  = sign_bit_i;
      cur_size  = decode_size(byte_sel_i);
      cur_addr  = addr_i;
      cur_data  = store_data_i;
      cur_rd    = rd_addr_i;
    end else begin
      cur_store = is_store_q;
      cur_sign  = sign_q;
      cur_size  = size_q;
      cur_addr  = addr_q;
      cur_data  = data_q;
      cur_rd    = rd_q;
    end
  end

`ifdef LDST_MISALIGN_CHK_EN
  assign misalign = ((cur_size == SZ_H) && cur_addr[0]) ||
                    ((cur_size == SZ_W) && (cur_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign idx            = cur_addr[AW+1:2];
  assign unused_addr_hi = ^cur_addr[WIDTH-1:AW+2];

  // Offset aligned down to the access size; also drives lane replication and strobes.
  always_comb begin
    case (cur_size)
      SZ_B: begin
        off   = cur_addr[1:0];
        wdata = WIDTH'({WORD_BYTES{cur_data[7:0]}});
        strb  = 4'b0001 << off;
      end
      SZ_H: begin
        off   = {cur_addr[1], 1'b0};
        wdata = WIDTH'({(WORD_BYTES/2){cur_data[15:0]}});
        strb  = 4'b0011 << off;
      end
      default: begin
        off   = 2'b00;
        wdata = cur_data;
        strb  = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    do_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          if (HAS_WAIT && !misalign) begin
            state_d = WAIT;
            cnt_d   = 4'd1;
          end else begin
            state_d = RESP;
            do_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == WAIT_CNT) begin
          state_d = RESP;
          cnt_d   = 4'd0;
          do_resp = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
      default: state_d = IDLE;
    endcase
    stall_pipeline_o = (state_q == WAIT) ||
                       ((state_q == IDLE) && any_valid && HAS_WAIT && !misalign);
  end

  assign load_resp = do_resp && !cur_store && !misalign;
  assign mem_we    = do_resp && cur_store && !misalign && !risc_rst;
  assign rd_word   = mem[idx];

  ldst_load_align #(
    .WIDTH (WIDTH)
  ) u_load_align (
    .word_i   (rd_word),
    .offset_i (off),
    .size_i   (cur_size),
    .sign_i   (cur_sign),
    .data_o   (ld_data)
  );

  // Memory contents are deliberately left out of reset.
  always_ff @(posedge risc_clk) begin
    if (mem_we) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (strb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge risc_clk or posedge risc_rst) begin
    if (risc_rst) begin
      state_q        <= IDLE;
      cnt_q          <= 4'd0;
      is_store_q     <= 1'b0;
      sign_q         <= 1'b0;
      size_q         <= SZ_B;
      addr_q         <= '0;
      data_q         <= '0;
      rd_q           <= 5'd0;
      reg_wr_en_o    <= 1'b0;
      reg_wr_addr_o  <= 5'd0;
      reg_wr_data_o  <= '0;
      store_done_o   <= 1'b0;
      misalign_err_o <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        is_store_q <= store_valid_in;
        sign_q     <= sign_bit_i;
        size_q     <= decode_size(byte_sel_i);
        addr_q     <= addr_i;
        data_q     <= store_data_i;
        rd_q       <= rd_addr_i;
      end
      reg_wr_en_o    <= load_resp && (cur_rd != 5'd0);
      reg_wr_addr_o  <= load_resp ? cur_rd : 5'd0;
      reg_wr_data_o  <= load_resp ? ld_data : '0;
      store_done_o   <= do_resp && cur_store && !misalign;
      misalign_err_o <= do_resp && misalign;
    end
  end

endmodule

// File: tb/tb_ldst_mem_responder.sv
// Scoreboard bench for ldst_mem_responder (WAIT_CYCLES=1); honours LDST_MISALIGN_CHK_EN if defined.
module tb_ldst_mem_responder;

  localparam int unsigned WC = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ld_v = 1'b0, st_v = 1'b0;
  logic [31:0] addr = '0, sdata = '0;
  logic [1:0]  sel = 2'b10;
  logic        sgn = 1'b0;
  logic [4:0]  rd = '0;
  logic        stall, wr_en, st_done, mis;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int tag     = 0;

  typedef struct {
    int          id;
    bit          is_load;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        sd;
    logic        me;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  ldst_mem_responder #(
    .WIDTH       (32),
    .DEPTH_WORDS (1024),
    .WAIT_CYCLES (WC)
  ) dut (
    .risc_clk         (clk),
    .risc_rst         (rst),
    .load_valid_in    (ld_v),
    .store_valid_in   (st_v),
    .addr_i           (addr),
    .store_data_i     (sdata),
    .byte_sel_i       (sel),
    .sign_bit_i       (sgn),
    .rd_addr_i        (rd),
    .stall_pipeline_o (stall),
    .reg_wr_en_o      (wr_en),
    .reg_wr_addr_o    (wr_addr),
    .reg_wr_data_o    (wr_data),
    .store_done_o     (st_done),
    .misalign_err_o   (mis)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic ok, input string got, input string want);
    n_tests++;
    if (ok !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: got %s, want %s", name, got, want);
    end
  endtask

  // Monitor: any response-looking output pops the oldest expectation.
  always @(negedge clk) begin
    exp_t  e;
    logic  ok;
    string got;
    if (!rst && (wr_en || st_done || mis || wr_data != 32'h0)) begin
      got = $sformatf("we=%0b wa=%0d wd=%08h sd=%0b me=%0b cyc=%0d",
                      wr_en, wr_addr, wr_data, st_done, mis, cyc);
      if (sb.size() == 0) begin
        check("unexpected_resp", 1'b0, got, "no response");
      end else begin
        e  = sb.pop_front();
        ok = (wr_en === e.we) && (st_done === e.sd) && (mis === e.me) && (cyc == e.cyc) &&
             (!e.is_load || ((wr_addr === e.wa) && (wr_data === e.wd)));
        check($sformatf("resp#%0d", e.id), ok, got,
              $sformatf("we=%0b wa=%0d wd=%08h sd=%0b me=%0b cyc=%0d",
                        e.we, e.wa, e.wd, e.sd, e.me, e.cyc));
      end
    end
  end

  function automatic exp_t mk(input bit is_load, input logic we, input logic [4:0] wa,
                              input logic [31:0] wd, input logic sd, input logic me);
    exp_t e;
    e.id = 0; e.is_load = is_load; e.we = we; e.wa = wa; e.wd = wd;
    e.sd = sd; e.me = me; e.cyc = 0;
    return e;
  endfunction

  task automatic issue(input logic l, input logic s, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input logic sg, input logic [4:0] r,
                       input exp_t e_in);
    exp_t e;
    logic exp_stall;
    e = e_in;
    @(negedge clk);
    ld_v = l; st_v = s; addr = a; sdata = d; sel = sz; sgn = sg; rd = r;
    #1;
    exp_stall = (WC != 0) && !e.me;
    check("stall_req", stall === exp_stall, $sformatf("%0b", stall), $sformatf("%0b", exp_stall));
    tag++;
    e.id  = tag;
    e.cyc = cyc + (e.me ? 1 : int'(WC) + 1);
    sb.push_back(e);
    @(posedge clk);
    #1;
    ld_v = 1'b0; st_v = 1'b0;
    if (!e.me) begin
      for (int k = 1; k <= int'(WC); k++) begin
        @(negedge clk);
        check("stall_wait", stall === 1'b1, $sformatf("%0b", stall), "1");
      end
    end
    @(negedge clk);
    check("stall_resp", stall === 1'b0, $sformatf("%0b", stall), "0");
  endtask

  task automatic ld(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                    input logic [4:0] r, input logic [31:0] exp_d);
    issue(1'b0 | 1'b1, 1'b0, a, 32'h0, sz, sg, r, mk(1'b1, r != 5'd0, r, exp_d, 1'b0, 1'b0));
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    issue(1'b0, 1'b1, a, d, sz, 1'b0, 5'd0, mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {stall, wr_en, st_done, mis, wr_addr, wr_data} === '0,
          $sformatf("%0b%0b%0b%0b %0d %08h", stall, wr_en, st_done, mis, wr_addr, wr_data), "all 0");
    @(negedge clk);
    rst = 1'b0;

    // 1: word store and readback
    st(32'h10, 32'hDEADBEEF, 2'b10);
    ld(32'h10, 2'b10, 1'b0, 5'd5, 32'hDEADBEEF);
    // 2: lane select and extension
    ld(32'h13, 2'b00, 1'b1, 5'd6, 32'hFFFFFFDE);
    ld(32'h13, 2'b00, 1'b0, 5'd6, 32'h000000DE);
    ld(32'h12, 2'b01, 1'b1, 5'd7, 32'hFFFFDEAD);
    ld(32'h10, 2'b01, 1'b0, 5'd7, 32'h0000BEEF);
    ld(32'h10, 2'b00, 1'b1, 5'd8, 32'hFFFFFFEF);
    // 3: byte and half strobes
    st(32'h11, 32'hFFFFFF5A, 2'b00);
    ld(32'h10, 2'b10, 1'b0, 5'd5, 32'hDEAD5AEF);
    ld(32'h11, 2'b00, 1'b1, 5'd5, 32'h0000005A);
    st(32'h12, 32'hABCD1234, 2'b01);
    ld(32'h10, 2'b10, 1'b0, 5'd5, 32'h12345AEF);
    ld(32'h10, 2'b11, 1'b0, 5'd4, 32'h12345AEF);
    ld(32'h1010, 2'b10, 1'b0, 5'd3, 32'h12345AEF);
    // 4: x0 destination, then simultaneous load+store
    ld(32'h10, 2'b10, 1'b0, 5'd0, 32'h12345AEF);
    issue(1'b1, 1'b1, 32'h14, 32'h0BADF00D, 2'b10, 1'b0, 5'd7,
          mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0));
    ld(32'h14, 2'b10, 1'b0, 5'd7, 32'h0BADF00D);

    // 5: reset during the wait state of a store
    st(32'h20, 32'h12345678, 2'b10);
    @(negedge clk);
    st_v = 1'b1; addr = 32'h20; sdata = 32'hCAFEF00D; sel = 2'b10;
    @(posedge clk);
    #1;
    st_v = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_outputs", {stall, wr_en, st_done, mis, wr_addr, wr_data} === '0,
          $sformatf("%0b%0b%0b%0b %0d %08h", stall, wr_en, st_done, mis, wr_addr, wr_data), "all 0");
    @(negedge clk);
    rst = 1'b0;
    ld(32'h20, 2'b10, 1'b0, 5'd8, 32'h12345678);

    // 6: misaligned word load
`ifdef LDST_MISALIGN_CHK_EN
    issue(1'b1, 1'b0, 32'h12, 32'h0, 2'b10, 1'b0, 5'd9,
          mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1));
`else
    ld(32'h12, 2'b10, 1'b0, 5'd9, 32'h12345AEF);
`endif

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size() == 0, $sformatf("%0d pending", sb.size()), "0 pending");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
